// File: rtl/video_sync_gen.sv
// video_sync_gen: raster timing generator placed between the PPU and the
// palette/colour stage. Follows the core's beam counters while they carry
// frame starts, and coasts on internal h/v counters when the core stalls or is
// held in reset, so the scaler downstream always sees a stable raster.
module video_sync_gen #(
  parameter int CE_DIV        = 4,
  parameter int H_TOTAL       = 341,
  parameter int V_TOTAL_NTSC  = 262,
  parameter int V_TOTAL_PAL   = 312,
  parameter int H_ACTIVE      = 256,
  parameter int H_VISIBLE     = 280,
  parameter int V_ACTIVE      = 240,
  parameter int HS_START      = 279,
  parameter int HS_END        = 304,
  parameter int VS_START_NTSC = 243,
  parameter int VS_START_PAL  = 270,
  parameter int VS_LEN        = 3,
  parameter int CROP_V        = 8,
  parameter int CROP_H        = 19,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] core_h,
  input  logic [8:0] core_v,
  input  logic       pal_video,
  input  logic       hide_overscan,
  output logic       ce_pix,
  output logic       ce_eval,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       is_padding,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       freerun,
  output logic       hold_reset
);

  localparam int PHASE_W = $clog2(CE_DIV);
  localparam int MISS_W  = $clog2(LOCK_FRAMES + 1);

  localparam logic [PHASE_W-1:0] PHASE_EVAL = PHASE_W'(CE_DIV / 2);
  localparam logic [MISS_W-1:0]  MISS_SAT   = MISS_W'(LOCK_FRAMES);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOCK_FRAMES - 1);

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST_NTSC = 10'(V_TOTAL_NTSC - 1);
  localparam logic [9:0] V_LAST_PAL  = 10'(V_TOTAL_PAL - 1);
  localparam logic [9:0] H_ACT_W     = 10'(H_ACTIVE);
  localparam logic [9:0] HS_START_W  = 10'(HS_START);
  localparam logic [9:0] HS_END_W    = 10'(HS_END);
  localparam logic [9:0] CROP_V_W    = 10'(CROP_V);

  typedef enum logic [1:0] {LOCKED, COAST, FREERUN} sync_state_t;

  sync_state_t        state;
  logic [MISS_W-1:0]  miss_cnt;
  logic [PHASE_W-1:0] phase;
  logic               reset_d;
  logic               reset_entry;
  logic [9:0]         h_cnt;
  logic [9:0]         v_cnt;
  logic [8:0]         core_v_prev;
  logic               resync;
  logic               line_end;
  logic               frame_end;
  logic               use_internal;
  logic [9:0]         v_last;
  logic [9:0]         h_vis_edge;
  logic [9:0]         v_act_edge;
  logic [9:0]         vs_start;
  logic [9:0]         vs_stop;

  // Reset values are loaded on the first cycle of a reset; while reset stays
  // high the divider and internal raster keep running so the output coasts.
  assign reset_entry = reset & ~reset_d;

  // Pixel divider: ce_pix at phase 0, ce_eval half a pixel later.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    reset_d <= reset;
    if (reset_entry) begin
      phase   <= '0;
      ce_pix  <= 1'b0;
      ce_eval <= 1'b0;
    end else begin
      phase   <= phase + 1'b1;
      ce_pix  <= (phase == '0);
      ce_eval <= (phase == PHASE_EVAL);
    end
  end

  // Source selection and compare thresholds for the current mode.
  always_comb begin
    // NOTE: every signal in this block is assigned on every path, so no
    // latch is inferred.
    use_internal = reset || (state == FREERUN);
    x            = use_internal ? h_cnt : {1'b0, core_h};
    y            = use_internal ? v_cnt : {1'b0, core_v};
    v_last       = pal_video ? V_LAST_PAL : V_LAST_NTSC;
    h_vis_edge   = hide_overscan ? 10'(H_VISIBLE - CROP_H) : 10'(H_VISIBLE);
    v_act_edge   = hide_overscan ? 10'(V_ACTIVE - CROP_V) : 10'(V_ACTIVE);
    vs_start     = pal_video ? 10'(VS_START_PAL) : 10'(VS_START_NTSC);
    vs_stop      = vs_start + 10'(VS_LEN);
  end

  assign resync     = (core_v_prev == 9'd511) && (core_v == 9'd0);
  assign line_end   = (h_cnt >= H_LAST);
  // v_last is only consulted at line end, so a pal_video change mid-line
  // cannot cut the current line short.
  assign frame_end  = line_end && (v_cnt >= v_last);
  assign freerun    = use_internal;
  assign is_padding = (x >= H_ACT_W);

  // Internal raster counters; a core frame start (511 -> 0) realigns them.
  always_ff @(posedge clk) begin
    if (reset_entry) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      core_v_prev <= '0;
    end else if (ce_eval) begin
      core_v_prev <= core_v;
      if (resync) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (line_end) begin
        h_cnt <= '0;
        v_cnt <= frame_end ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Lock tracker: counts internal frames without a core frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= FREERUN;
      miss_cnt <= '0;
    end else if (ce_eval) begin
      if (resync) begin
        miss_cnt <= '0;
        state    <= LOCKED;
      end else if (frame_end) begin
        if (miss_cnt >= MISS_LAST) begin
          miss_cnt <= MISS_SAT;
          state    <= FREERUN;
        end else begin
          miss_cnt <= miss_cnt + 1'b1;
          if (state == LOCKED) state <= COAST;
        end
      end
    end
  end

  // Sync and blank flags, registered once per pixel from the selected x/y.
  always_ff @(posedge clk) begin
    if (reset_entry) begin
      hsync  <= 1'b0;
      vsync  <= 1'b0;
      hblank <= 1'b0;
      vblank <= 1'b0;
    end else if (ce_pix) begin
      hblank <= (x >= h_vis_edge) && (x <= H_LAST);
      vblank <= (y >= v_act_edge) || (hide_overscan && (y < CROP_V_W));
      if (x == HS_START_W) begin
        hsync <= 1'b1;
        vsync <= (y >= vs_start) && (y < vs_stop);
      end else if (x == HS_END_W) begin
        hsync <= 1'b0;
      end
    end
  end

  // hold_reset stays high until the internal raster returns to the origin.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reset <= 1'b1;
    end else if ((h_cnt == '0) && (v_cnt == '0)) begin
      hold_reset <= 1'b0;
    end
  end

endmodule

// File: doc/video_sync_gen.md
Name: video_sync_gen

Overview:
Parametrised raster timing generator for console cores. It generalises the fixed NES video timing into configurable H/V totals, active and visible windows, sync positions, PAL/NTSC line counts, overscan crop and pixel-clock division. It tracks the core's PPU beam counters and coasts on internal counters when the core stalls or is held in reset, so the scaler always receives a stable raster. It sits between the PPU and the palette/colour stage.

Parameters:
CE_DIV, 4, clk cycles per pixel; power of two, at least 2
H_TOTAL, 341, pixels per line
V_TOTAL_NTSC, 262, lines per frame when pal_video=0
V_TOTAL_PAL, 312, lines per frame when pal_video=1
H_ACTIVE, 256, pixels carrying image data; x >= H_ACTIVE is padding
H_VISIBLE, 280, pixels before hblank, including padding
V_ACTIVE, 240, visible lines
HS_START, 279, hsync rise column
HS_END, 304, hsync fall column
VS_START_NTSC, 243, first vsync line (NTSC)
VS_START_PAL, 270, first vsync line (PAL)
VS_LEN, 3, vsync length in lines
CROP_V, 8, lines removed top and bottom when hide_overscan=1
CROP_H, 19, right-edge columns removed when hide_overscan=1
LOCK_FRAMES, 2, consecutive frames without core frame-start before free-run

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
core_h  in  9  PPU horizontal counter
core_v  in  9  PPU vertical counter; 511 then 0 marks frame start
pal_video  in  1  selects PAL totals and vsync line
hide_overscan  in  1  enables crop
ce_pix  out  1  pixel strobe, one clk wide, every CE_DIV clocks
ce_eval  out  1  mid-pixel strobe, CE_DIV/2 clocks after ce_pix
x  out  10  current column used for timing
y  out  10  current line used for timing
is_padding  out  1  x >= H_ACTIVE
hsync  out  1  horizontal sync, active-high
vsync  out  1  vertical sync, active-high
hblank  out  1  horizontal blank
vblank  out  1  vertical blank
freerun  out  1  timing taken from internal counters
hold_reset  out  1  high from reset until internal counters reach (0,0)

Behaviour:
- Reset is synchronous, active-high; the clock is clk.
- Reset values: phase=0; internal h=0, v=0; miss count=0; state FREERUN; all sync and blank outputs 0; hold_reset=1; ce_pix=0; ce_eval=0.
- Divider: phase counts 0..CE_DIV-1 and wraps. ce_pix is registered high when phase==0. ce_eval is registered high when phase==CE_DIV/2. The divider runs during reset.
- Internal counters advance on ce_eval. h wraps at H_TOTAL-1 to 0. On wrap, v increments and wraps at V_TOTAL-1, where V_TOTAL is selected by the current pal_video.
- Resync: on ce_eval, if the previous sampled core_v==511 and the current core_v==0, then h, v and the miss count clear to 0. The resync overrides the normal increment.
- States:
  - LOCKED: x/y = core_h/core_v, zero-extended.
  - COAST: x/y = core_h/core_v, zero-extended; miss count is nonzero.
  - FREERUN: x/y = internal h/v.
- Transitions, evaluated on ce_eval:
  - Every internal v wrap without a resync increments the miss count, saturating at LOCK_FRAMES.
  - Miss count reaching LOCK_FRAMES → FREERUN.
  - Any resync → LOCKED.
  - While reset=1, x/y use the internal counters regardless of state.
- freerun = (state==FREERUN) or reset.
- Timing outputs are evaluated on ce_pix from x/y and registered:
  - hblank = x >= H_VISIBLE - (hide_overscan ? CROP_H : 0) and x <= H_TOTAL-1.
  - vblank = y >= V_ACTIVE - (hide_overscan ? CROP_V : 0), or (hide_overscan and y < CROP_V).
  - hsync sets at x==HS_START and clears at x==HS_END.
  - vsync is updated only at x==HS_START: high iff VS_START <= y < VS_START+VS_LEN.
- is_padding is combinational from x.
- hold_reset clears when internal h==0 and v==0 and reset==0. It sets whenever reset==1.
- Changing pal_video mid-frame takes effect at the next line-end compare; no glitch on the current line.
- Core counters out of range (core_h >= H_TOTAL) pass through unchanged. Blank compares still apply.

Test Plan:
- CE_DIV=4, reset released → ce_pix high at phases 0,4,8…; ce_eval at 2,6…; hold_reset drops when internal (h,v) first reaches (0,0).
- Core drives NTSC counters with a 511→0 frame start → freerun=0 after the first resync; hsync rises at x=279, falls at x=304; vsync high for y=243..245 only.
- hide_overscan=1 → vblank for y<8 and y>=232; hblank from x=261 to 340.
- Core counters frozen at (100,50) for 2 internal frames → freerun=1 at the second v wrap; x/y continue 0..340 / 0..261. The next 511→0 frame start → LOCKED, x/y=0.
- pal_video=1 in free-run → v wraps after 311; vsync on lines 270..272.
- Reset asserted mid-line at h=150 → freerun=1 immediately; hold_reset=1 until the internal counters wrap to (0,0).
